mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency on-chip/off-chip memory between the two master channels (lane 0, lane 1) of a generated accelerator's external memory interface.
- Sits between the accelerator's Mout_* bus and the memory macro.
- Claims only addresses inside its window, serialises accesses with round-robin priority, and generates per-lane M_DataRdy pulses and read data.
- Out-of-window traffic is left for other slaves; this block returns zero data and no ready for it, so its outputs can be OR-ed onto the shared bus.

Parameters:
- ADDR_W, 7, width of one lane's address field.
- DATA_W, 8, width of one lane's data field.
- SIZE_W, 4, width of one lane's access-size field (size in bits).
- MEM_BASE, 0, first claimed address.
- MEM_DEPTH, 32, number of claimed words; the window is [MEM_BASE, MEM_BASE+MEM_DEPTH).
- RD_LAT, 2, cycles from mem_en (read) to mem_rdata valid; must be at least 1.
- WR_LAT, 1, cycles from mem_en (write) to write-ready; must be at least 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- Mout_oe_ram  in  2  per-lane read request, level, held until M_DataRdy.
- Mout_we_ram  in  2  per-lane write request, level, held until M_DataRdy.
- Mout_addr_ram  in  2*ADDR_W  lane i at [i*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  2*DATA_W  per-lane write data.
- Mout_data_ram_size  in  2*SIZE_W  per-lane access size in bits.
- M_Rdata_ram  out  2*DATA_W  per-lane read data; zero except in that lane's response cycle.
- M_DataRdy  out  2  per-lane one-cycle completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address relative to MEM_BASE.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  DATA_W  bit write mask.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after a read mem_en.
- err_we_oe  out  1  sticky flag: a lane asserted oe and we together.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; last_grant=1, so lane 0 wins the first tie.
  - All outputs 0, including err_we_oe.
  - An in-flight access is abandoned: no DataRdy, and late mem_rdata is ignored.
- Per-lane request: req[i] = (oe[i] ^ we[i]) && MEM_BASE <= addr_i < MEM_BASE+MEM_DEPTH.
  - Lanes with oe and we both high are never granted.
  - Such a lane sets err_we_oe, which stays set until reset.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick grant g: the sole requester, or on a tie the lane != last_grant.
  - Latch g, we[g], addr-MEM_BASE, wdata and the mask; go to ACCESS.
- ACCESS (1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata/mem_wmask driven from the latched values.
  - Load cnt = LAT-1, where LAT is RD_LAT for a read and WR_LAT for a write.
  - Go to WAIT if cnt>0, else RESP.
- WAIT: decrement cnt each cycle; go to RESP when cnt reaches 0.
- RESP (1 cycle):
  - M_DataRdy[g]=1.
  - For a read, M_Rdata_ram lane g = mem_rdata & mask; the other lane's data is 0.
  - last_grant=g; go to IDLE.
- Latency: a request sampled in IDLE at cycle t gives mem_en at t+1 and M_DataRdy at t+1+LAT.
  - The next grant is sampled no earlier than t+2+LAT.
  - The lane must have deasserted its request by then; a still-high request is treated as a new access.
- Mask = (1<<size)-1, truncated to DATA_W.
  - size >= DATA_W gives all ones.
  - size 0 gives mask 0: the write is a no-op but is still acknowledged, and a read returns 0.
- Outside ACCESS, mem_* outputs are 0.
- A request that drops during ACCESS/WAIT does not cancel the access; DataRdy is still pulsed.
- Addresses at MEM_BASE+MEM_DEPTH and above, or below MEM_BASE, are never claimed.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - N_LANES=2;
  - default RD_LAT/WR_LAT;
  - a size-to-mask function.
- One sub-module, mem_arb_rr2: a 2-way round-robin grant with a last_grant register, combinational grant plus registered update on RESP.

Test Plan:
- Lane 0 read at addr 5, memory[5]=0xA7, RD_LAT=2 -> mem_en at t+1, M_DataRdy=2'b01 and M_Rdata_ram[7:0]=0xA7 at t+3; lane 1 data=0.
- Lane 1 write 0x3C with size 4 to addr 2, memory held 0xF0 -> mem_wmask=0x0F; memory becomes 0xFC; M_DataRdy=2'b10 at t+2.
- Both lanes read in the same cycle after reset -> lane 0 is served first, then lane 1; two consecutive rounds alternate 0,1,0,1.
- Lane 0 asserts oe=we=1 -> no mem_en and no DataRdy; err_we_oe=1 and stays 1 until reset=0.
- Lane 0 read at addr 32 (out of window, MEM_DEPTH=32) -> no mem_en; M_DataRdy=0; M_Rdata_ram=0.
- Reset=0 asserted during WAIT of a read -> next cycle all outputs 0 and state IDLE; a read issued after reset completes normally at t+3.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state type, lane count, default latencies and size-to-mask helper
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam int N_LANES = 2;
  localparam int RD_LAT_DEF = 2;
  localparam int WR_LAT_DEF = 1;
  function automatic logic [63:0] size_mask(input int unsigned size);
    return size >= 64 ? '1 : (64'd1 << size) - 64'd1;
  endfunction
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: 2-way round-robin grant (clock, reset active-low, req in, update/served record the completed lane, grant out)
module mem_arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [N_LANES-1:0] req,
  input  logic               update,
  input  logic               served,
  output logic               grant
);
  logic last_grant;
  always_comb grant = req == 2'b10 ? 1'b1 : req == 2'b01 ? 1'b0 : ~last_grant;
  always_ff @(posedge clock) last_grant <= !reset ? 1'b1 : update ? served : last_grant;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one fixed-latency memory between two Mout lanes (clock/reset, Mout_* in, M_Rdata_ram/M_DataRdy out, mem_* port, sticky err_we_oe)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int MEM_BASE  = 0,
  parameter int MEM_DEPTH = 32,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int WR_LAT    = WR_LAT_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_LANES-1:0]          Mout_oe_ram,
  input  logic [N_LANES-1:0]          Mout_we_ram,
  input  logic [N_LANES*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_LANES*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_LANES*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [N_LANES*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_LANES-1:0]          M_DataRdy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W-1:0]           mem_wmask,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        err_we_oe
);
  localparam int MAX_LAT = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  state_t state;
  logic [N_LANES-1:0] req;
  logic [ADDR_W-1:0] a [N_LANES];
  logic [DATA_W-1:0] wd [N_LANES];
  logic [SIZE_W-1:0] sz [N_LANES];
  logic gnt, g, we_l;
  logic [DATA_W-1:0] mask_g, mask_l;
  logic [CNT_W-1:0] cnt;
  int lat;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign a[i] = Mout_addr_ram[i*ADDR_W +: ADDR_W];
    assign wd[i] = Mout_Wdata_ram[i*DATA_W +: DATA_W];
    assign sz[i] = Mout_data_ram_size[i*SIZE_W +: SIZE_W];
    assign req[i] = (Mout_oe_ram[i] ^ Mout_we_ram[i]) && int'(a[i]) >= MEM_BASE && int'(a[i]) < MEM_BASE + MEM_DEPTH;
    assign M_Rdata_ram[i*DATA_W +: DATA_W] = M_DataRdy[i] && !we_l ? mem_rdata & mask_l : '0;
  end
  always_comb mask_g = DATA_W'(size_mask(int'(sz[gnt])));
  always_comb lat = we_l ? WR_LAT : RD_LAT;
  mem_arb_rr2 u_rr (
    .clock(clock),
    .reset(reset),
    .req(req),
    .update(state == RESP),
    .served(g),
    .grant(gnt)
  );
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      g <= 1'b0;
      we_l <= 1'b0;
      mask_l <= '0;
      cnt <= '0;
      err_we_oe <= 1'b0;
      M_DataRdy <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      err_we_oe <= err_we_oe | (|(Mout_oe_ram & Mout_we_ram));
      M_DataRdy <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      case (state)
        IDLE: if (|req) begin
          state <= ACCESS;
          g <= gnt;
          we_l <= Mout_we_ram[gnt];
          mask_l <= mask_g;
          mem_en <= 1'b1;
          mem_we <= Mout_we_ram[gnt];
          mem_addr <= a[gnt] - ADDR_W'(MEM_BASE);
          mem_wdata <= wd[gnt];
          mem_wmask <= mask_g;
        end
        ACCESS: begin
          cnt <= CNT_W'(lat - 1);
          state <= lat > 1 ? WAIT : RESP;
          M_DataRdy <= lat > 1 ? '0 : N_LANES'(1) << g;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          state <= cnt == CNT_W'(1) ? RESP : WAIT;
          M_DataRdy <= cnt == CNT_W'(1) ? N_LANES'(1) << g : '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level memory/arbitration model
module tb_mem_port_arbiter;
  localparam int AW = 7, DW = 8, SW = 4, BASE = 0, DEPTH = 32, RL = 2, WL = 1;
  logic clock = 0, reset = 0;
  logic [1:0] oe = '0, we = '0;
  logic [AW-1:0] addr [2] = '{default: '0};
  logic [DW-1:0] wdata [2] = '{default: '0};
  logic [SW-1:0] size [2] = '{default: '0};
  logic [2*DW-1:0] rdata;
  logic [1:0] rdy;
  logic mem_en, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_wmask, mem_rdata;
  logic [DW-1:0] junk = '0;
  logic [DW-1:0] macro [128] = '{default: '0};
  logic [DW-1:0] model [128] = '{default: '0};
  logic [DW-1:0] pd [RL] = '{default: '0};
  logic [RL-1:0] pv = '0;
  int checks = 0, failures = 0, last = 1, g;
  logic err_exp = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .RD_LAT(RL), .WR_LAT(WL)) dut (
    .clock(clock),
    .reset(reset),
    .Mout_oe_ram(oe),
    .Mout_we_ram(we),
    .Mout_addr_ram({addr[1], addr[0]}),
    .Mout_Wdata_ram({wdata[1], wdata[0]}),
    .Mout_data_ram_size({size[1], size[0]}),
    .M_Rdata_ram(rdata),
    .M_DataRdy(rdy),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata),
    .err_we_oe(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en && mem_we) macro[mem_addr] <= (macro[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    pv <= {pv[RL-2:0], mem_en && !mem_we};
    pd[0] <= macro[mem_addr];
    for (int i = 1; i < RL; i++) pd[i] <= pd[i-1];
    junk <= DW'($urandom);
  end
  assign mem_rdata = pv[RL-1] ? pd[RL-1] : junk;

  function automatic logic [DW-1:0] mask_of(input int s);
    return s >= DW ? '1 : DW'((1 << s) - 1);
  endfunction

  function automatic bit req_of(input int i);
    return (oe[i] ^ we[i]) && int'(addr[i]) >= BASE && int'(addr[i]) < BASE + DEPTH;
  endfunction

  function automatic logic [63:0] busy();
    return 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_wmask, rdy, rdata});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input int i, input bit o, input bit w, input int a, input int d, input int s);
    oe[i] = o;
    we[i] = w;
    addr[i] = AW'(a);
    wdata[i] = DW'(d);
    size[i] = SW'(s);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk(tag, busy(), 64'(0));
    end
  endtask

  task automatic serve(output int gl);
    int lat;
    logic [DW-1:0] m;
    logic [2*DW-1:0] exp_d;
    gl = req_of(0) && req_of(1) ? 1 - last : req_of(0) ? 0 : req_of(1) ? 1 : -1;
    if (gl < 0) begin
      idle_check("no_claim", 3);
      return;
    end
    m = mask_of(int'(size[gl]));
    lat = we[gl] ? WL : RL;
    exp_d = we[gl] ? '0 : {{DW{1'b0}}, model[addr[gl]] & m} << (gl * DW);
    @(negedge clock);
    chk("acc_en", 64'(mem_en), 64'(1));
    chk("acc_we", 64'(mem_we), 64'(we[gl]));
    chk("acc_addr", 64'(mem_addr), 64'(addr[gl] - AW'(BASE)));
    chk("acc_mask", 64'(mem_wmask), 64'(m));
    chk("acc_rdy", 64'(rdy), 64'(0));
    if (we[gl]) chk("acc_wdata", 64'(mem_wdata), 64'(wdata[gl]));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k < lat) chk("wait_quiet", busy(), 64'(0));
    end
    chk("resp_rdy", 64'(rdy), 64'(1 << gl));
    chk("resp_rdata", 64'(rdata), 64'(exp_d));
    chk("resp_mem_quiet", 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_wmask}), 64'(0));
    chk("resp_err", 64'(err), 64'(err_exp));
    if (we[gl]) begin
      model[addr[gl]] = (model[addr[gl]] & ~m) | (wdata[gl] & m);
      chk("mem_word", 64'(macro[addr[gl]]), 64'(model[addr[gl]]));
    end
    last = gl;
    oe[gl] = 1'b0;
    we[gl] = 1'b0;
    @(negedge clock);
    chk("idle_after", busy(), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_outs", busy(), 64'(0));
    chk("reset_err", 64'(err), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    set(0, 0, 1, 5, 8'hA7, 8); serve(g);
    set(1, 0, 1, 2, 8'hF0, 15); serve(g);
    set(0, 1, 0, 5, 0, 8); serve(g);
    set(1, 0, 1, 2, 8'h3C, 4); serve(g);
    chk("tp_merge_fc", 64'(macro[2]), 64'(8'hFC));
    set(0, 1, 0, 2, 0, 12); serve(g);
    set(0, 0, 1, 5, 8'h55, 0); serve(g);
    set(1, 1, 0, 5, 0, 0); serve(g);
    set(1, 1, 0, 5, 0, 3); serve(g);
    set(0, 1, 0, 32, 0, 8); serve(g);
    set(0, 1, 0, 127, 0, 8); serve(g);
    oe = '0; we = '0;
    set(0, 1, 1, 3, 0, 8); serve(g);
    err_exp = 1'b1;
    chk("err_set", 64'(err), 64'(1));
    oe = '0; we = '0;
    idle_check("err_quiet", 2);
    chk("err_sticky", 64'(err), 64'(1));
    set(1, 1, 0, 5, 0, 8); serve(g);
    set(0, 1, 0, 5, 0, 8);
    @(negedge clock);
    chk("rst_acc_en", 64'(mem_en), 64'(1));
    @(negedge clock);
    chk("rst_wait_rdy", 64'(rdy), 64'(0));
    reset = 1'b0; oe = '0;
    @(negedge clock);
    chk("rst_outs", busy(), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    err_exp = 1'b0; last = 1; reset = 1'b1;
    idle_check("rst_late_data", 2);
    for (int r = 0; r < 2; r++) begin
      set(0, 1, 0, 5, 0, 8);
      set(1, 1, 0, 2, 0, 8);
      serve(g); serve(g);
    end
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++) begin
        int op;
        op = $urandom_range(0, 2);
        set(i, op == 1, op == 2, $urandom_range(0, 9) == 0 ? $urandom_range(DEPTH, 127) : $urandom_range(0, DEPTH - 1), $urandom, $urandom_range(0, 15));
      end
      do serve(g); while (g >= 0);
      oe = '0; we = '0;
    end
    chk("final_err", 64'(err), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
